// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm
// Direct-mapped instruction cache with one word per line. It sits between the
// CPU fetch port and a slow instruction memory that uses a req/ack handshake.
// A hit returns the instruction combinationally in the same cycle. A miss
// raises a stall request and refills the line from memory.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   cpu_ce_i      fetch enable
//   cpu_addr_i    fetch byte address (bits [1:0] ignored)
//   cpu_data_o    fetched instruction, 0 (NOP) when not delivering
//   stallreq_o    stall request to the pipeline controller
//   flush_i       invalidate every line
//   mem_req_o     refill request, held until mem_ack_i
//   mem_addr_o    word-aligned refill address
//   mem_ack_i     one-cycle refill data strobe
//   mem_data_i    refill data
// ---------------------------------------------------------------------------
module icache_dm #(
   parameter int INDEX_W = 6,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_ce_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [DATA_W-1:0] cpu_data_o,
   output logic              stallreq_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W - 2;

   typedef enum logic {
      IDLE,
      REFILL
   } state_t;

   state_t              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [TAG_W-1:0]    tag_d  [LINES];
   logic [DATA_W-1:0]   data_q [LINES];
   logic [DATA_W-1:0]   data_d [LINES];
   logic                drop_q, drop_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

   logic [ADDR_W-1:0]   word_addr;
   logic [INDEX_W-1:0]  lookup_index;
   logic [TAG_W-1:0]    lookup_tag;
   logic [INDEX_W-1:0]  fill_index;
   logic [TAG_W-1:0]    fill_tag;
   logic                lookup_hit;

   // Split the fetch address and the latched refill address into index and
   // tag. A flush in the lookup cycle forces a miss so stale lines never hit.
   assign word_addr    = cpu_addr_i & ~ADDR_W'(3);
   assign lookup_index = word_addr[INDEX_W+1:2];
   assign lookup_tag   = word_addr[ADDR_W-1:INDEX_W+2];
   assign fill_index   = mem_addr_q[INDEX_W+1:2];
   assign fill_tag     = mem_addr_q[ADDR_W-1:INDEX_W+2];
   assign lookup_hit   = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag) && !flush_i;

   assign mem_req_o  = mem_req_q;
   assign mem_addr_o = mem_addr_q;

   // Next-state and output logic. A refill cannot be aborted: once in REFILL
   // the latched address is filled whatever the CPU does. A flush during the
   // refill sets the drop flag so the returning line is written invalid.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      drop_d     = drop_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      cpu_data_o = '0;
      stallreq_o = 1'b0;

      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (flush_i) begin
               valid_d = '0;
            end
            if (cpu_ce_i) begin
               if (lookup_hit) begin
                  cpu_data_o = data_q[lookup_index];
               end else begin
                  stallreq_o = 1'b1;
                  mem_req_d  = 1'b1;
                  mem_addr_d = word_addr;
                  state_d    = REFILL;
               end
            end
         end
         REFILL: begin
            stallreq_o = 1'b1;
            if (flush_i) begin
               valid_d = '0;
               drop_d  = 1'b1;
            end
            if (mem_ack_i) begin
               tag_d[fill_index]   = fill_tag;
               data_d[fill_index]  = mem_data_i;
               valid_d[fill_index] = ~(drop_q | flush_i);
               mem_req_d           = 1'b0;
               drop_d              = 1'b0;
               state_d             = IDLE;
            end
         end
      endcase

      if (rst) begin
         cpu_data_o = '0;
         stallreq_o = 1'b0;
      end
   end

   // Control state and valid bits; reset clears them and abandons any refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         drop_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         drop_q     <= drop_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // Tag and data arrays need no reset: the valid bits gate every use, and
   // while rst is high the write path is blocked so a stray ack changes nothing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

endmodule
